// File: rtl/seq_det_sched.sv
// Round-robin scheduler that feeds one W-bit word at a time, MSB first, through a
// shared overlapping Mealy pattern detector and reports the per-word match count.
`timescale 1ns/1ps
module seq_det_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IW   = $clog2(NREQ),
    parameter int CW   = $clog2(W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3:0]        cfg_pat,
    input  logic [2:0]        cfg_len,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              match,
    output logic              res_valid,
    output logic [IW-1:0]     res_id,
    output logic [CW-1:0]     res_count,
    input  logic              res_ready
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gid;
    logic [W-1:0]  r_shift;
    logic [3:0]    r_pat;
    logic [2:0]    r_len;
    logic [2:0]    r_hist;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_count;

    logic          w_any;
    logic [IW-1:0] w_grant;
    logic [2:0]    w_len_clamp;
    logic [3:0]    w_mask;
    logic [3:0]    w_hist_next;
    logic          w_enough;
    logic          w_last;

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin : grant_search
        int unsigned idx;
        w_any   = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(r_ptr) + k) % NREQ;
            if (!w_any && req_valid[idx]) begin
                w_any   = 1'b1;
                w_grant = IW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && (r_state == S_IDLE) && w_any)
            req_ready[w_grant] = 1'b1;
    end

    always_comb begin
        if (cfg_len == 3'd0)
            w_len_clamp = 3'd1;
        else if (cfg_len > 3'd4)
            w_len_clamp = 3'd4;
        else
            w_len_clamp = cfg_len;
    end

    always_comb begin
        case (r_len)
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            3'd3:    w_mask = 4'b0111;
            default: w_mask = 4'b1111;
        endcase
    end

    assign bit_valid   = (r_state == S_SHIFT);
    assign bit_out     = bit_valid & r_shift[W-1];
    assign w_hist_next = {r_hist, r_shift[W-1]};
    // A match needs at least len bits of this word, so history never leaks across grants.
    assign w_enough    = (32'(r_idx) + 32'd1) >= 32'(r_len);
    assign match       = bit_valid && w_enough && ((w_hist_next & w_mask) == (r_pat & w_mask));
    assign w_last      = (r_idx == CW'(W - 1));

    assign res_valid = (r_state == S_REPORT);
    assign res_id    = r_gid;
    assign res_count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_shift <= '0;
            r_pat   <= '0;
            r_len   <= 3'd1;
            r_hist  <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_shift <= req_data[w_grant*W +: W];
                        r_pat   <= cfg_pat;
                        r_len   <= w_len_clamp;
                        r_gid   <= w_grant;
                        r_ptr   <= (w_grant == IW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
                        r_hist  <= '0;
                        r_idx   <= '0;
                        r_count <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift <= {r_shift[W-2:0], 1'b0};
                    r_hist  <= w_hist_next[2:0];
                    r_idx   <= r_idx + 1'b1;
                    if (match)
                        r_count <= r_count + 1'b1;
                    if (w_last)
                        r_state <= S_REPORT;
                end
                S_REPORT: begin
                    if (res_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched: grants, per-bit match pulses, counts,
// backpressure, round-robin spacing and asynchronous abort.
`timescale 1ns/1ps
module tb_seq_det_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  cfg_pat;
    logic [2:0]  cfg_len;
    logic        bit_out;
    logic        bit_valid;
    logic        match;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [3:0]  res_count;
    logic        res_ready;

    int          vectors     = 0;
    int          miscompares = 0;
    time         last_grant  = 0;
    logic [7:0]  lane_word [4];

    seq_det_sched #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .match     (match),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full word: grant check, 8 shift cycles, REPORT held for 'hold' extra cycles.
    task automatic run_word(input int gid, input logic [3:0] vmask, input logic [3:0] pat,
                            input logic [2:0] len, input logic [7:0] exp_m, input int exp_cnt,
                            input int hold, input bit gap_chk);
        @(negedge clk);
        req_valid = vmask;
        req_data  = {lane_word[3], lane_word[2], lane_word[1], lane_word[0]};
        cfg_pat   = pat;
        cfg_len   = len;
        res_ready = 1'b0;
        #1;
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("idle_bit_valid", 32'(bit_valid), 32'd0);
        chk("grant", 32'(req_ready), 32'(1 << gid));
        if (gap_chk)
            chk("grant_gap", 32'($time - last_grant), 32'd100);
        last_grant = $time;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cfg_pat = ~pat;
                cfg_len = 3'd2;
            end
            #1;
            chk("bit_valid", 32'(bit_valid), 32'd1);
            chk("bit_out", 32'(bit_out), 32'(lane_word[gid][7-i]));
            chk("match", 32'(match), 32'(exp_m[7-i]));
            chk("shift_ready", 32'(req_ready), 32'd0);
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            #1;
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_id", 32'(res_id), 32'(gid));
            chk("res_count", 32'(res_count), 32'(exp_cnt));
            chk("report_ready", 32'(req_ready), 32'd0);
            chk("report_bit_valid", 32'(bit_valid), 32'd0);
        end
        res_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_data = '0; cfg_pat = '0; cfg_len = '0; res_ready = 1'b0;
        foreach (lane_word[i]) lane_word[i] = '0;
        @(negedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_bit_out", 32'(bit_out), 32'd0);
        chk("rst_bit_valid", 32'(bit_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        @(negedge clk); rst = 1'b1;

        // Pattern 101 on 1010_1010: matches at bits 3, 5, 7.
        lane_word[0] = 8'b1010_1010;
        run_word(0, 4'b0001, 4'b0101, 3'd3, 8'b0010_1010, 3, 0, 1'b0);
        // Length 1, then length 0 treated as 1.
        lane_word[1] = 8'hFF;
        run_word(1, 4'b0010, 4'b0001, 3'd1, 8'hFF, 8, 0, 1'b0);
        lane_word[2] = 8'hFF;
        run_word(2, 4'b0100, 4'b0001, 3'd0, 8'hFF, 8, 0, 1'b0);
        // 0011_1011 with pattern 1011: only the last bit matches at length 4.
        lane_word[3] = 8'b0011_1011;
        run_word(3, 4'b1000, 4'b1011, 3'd7, 8'b0000_0001, 1, 0, 1'b0);
        lane_word[0] = 8'b0011_1011;
        run_word(0, 4'b0001, 4'b1011, 3'd4, 8'b0000_0001, 1, 0, 1'b0);
        // No match across the word boundary.
        lane_word[1] = 8'b0000_0010;
        run_word(1, 4'b0010, 4'b0101, 3'd3, 8'h00, 0, 0, 1'b0);
        lane_word[1] = 8'b1000_0000;
        run_word(1, 4'b0010, 4'b0101, 3'd3, 8'h00, 0, 0, 1'b0);
        // Backpressure: pattern "10" (len 2, upper pattern bits ignored), 5 extra REPORT cycles.
        lane_word[2] = 8'b1101_0101;
        run_word(2, 4'b0100, 4'b0110, 3'd2, 8'b0010_1010, 3, 5, 1'b0);

        @(negedge clk);
        req_valid = '0; rst = 1'b0;
        #1;
        chk("rst2_res_valid", 32'(res_valid), 32'd0);
        chk("rst2_res_count", 32'(res_count), 32'd0);
        @(negedge clk); rst = 1'b1;

        // Round robin from ptr 0, all valid, counting zeros (len 1, pattern 0).
        lane_word[0] = 8'h0F; lane_word[1] = 8'h01; lane_word[2] = 8'hFF; lane_word[3] = 8'h80;
        run_word(0, 4'b1111, 4'b0000, 3'd1, 8'hF0, 4, 0, 1'b0);
        run_word(1, 4'b1111, 4'b0000, 3'd1, 8'hFE, 7, 0, 1'b1);
        run_word(2, 4'b1111, 4'b0000, 3'd1, 8'h00, 0, 0, 1'b1);
        run_word(3, 4'b1111, 4'b0000, 3'd1, 8'h7F, 7, 0, 1'b1);
        run_word(0, 4'b1111, 4'b0000, 3'd1, 8'hF0, 4, 0, 1'b1);

        // Abort at bit 4 of a req1 word.
        @(negedge clk);
        req_valid = 4'b0010; cfg_pat = 4'b0101; cfg_len = 3'd3; res_ready = 1'b0;
        #1;
        chk("abort_grant", 32'(req_ready), 32'b0010);
        repeat (4) @(negedge clk);
        #1;
        chk("abort_bit4_valid", 32'(bit_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        chk("abort_bit_out", 32'(bit_out), 32'd0);
        chk("abort_bit_valid", 32'(bit_valid), 32'd0);
        chk("abort_match", 32'(match), 32'd0);
        chk("abort_res_valid", 32'(res_valid), 32'd0);
        chk("abort_res_id", 32'(res_id), 32'd0);
        chk("abort_res_count", 32'(res_count), 32'd0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("abort_hold_res_valid", 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1; req_valid = '0;
        #1;
        chk("abort_release_res_valid", 32'(res_valid), 32'd0);
        run_word(0, 4'b0011, 4'b0000, 3'd1, 8'hF0, 4, 0, 1'b0);

        @(negedge clk);
        req_valid = '0;
        #1;
        chk("final_res_valid", 32'(res_valid), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
